serial_adder: RTL

- Parametrised, bit-serial successor to the single-bit half adder.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first.
- Uses the same XOR-sum / AND-carry cell, extended with a carry-in term, plus a carry register.
- Uses a start/ready/done handshake and reports sum, carry-out and signed overflow; sits wherever area matters more than latency.

---
 rtl/serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first.
// Start/ready/done handshake; S/COUT/OVF held until next completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN =
    (WIDTH > 1) ? CW'(WIDTH - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic             cmsb_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             s_bit;
  logic             c_d;
  logic [WIDTH:0]   cat;
  logic [WIDTH-1:0] r_d;

  // Full-adder cell: the half-adder XOR/AND pair plus a carry-in term
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_d   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign cat   = {s_bit, r_q};
  assign r_d   = cat[WIDTH:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            c_q     <= SUB ? ~CIN : CIN;
            // WIDTH=1: carry into the MSB is the initial carry
            cmsb_q  <= SUB ? ~CIN : CIN;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if ((WIDTH > 1) && (cnt_q == MSB_IN)) begin
            cmsb_q <= c_d;
          end
          if (cnt_q == LAST) begin
            state_q <= DONE;
            s_q     <= r_d;
            cout_q  <= c_d;
            ovf_q   <= c_d ^ cmsb_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign COUT  = cout_q;
  assign OVF   = ovf_q;

endmodule
